board_lock_clear: RTL

- Downstream consumer of the tetromino shape ROM output.
- Stamps a 4x4 piece mask (four 4-bit rows, same format as the shape ROM) into the 20x10 playfield at a given position.
- Then scans for full rows, collapses them and reports the number of lines cleared.
- Owns the playfield register array that the renderer reads.

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/piece_stamp.sv | 42 ++++
 rtl/board_lock_clear.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield/piece types and constants for the lock-and-clear datapath.
package tetris_pkg;

   localparam int BOARD_ROWS = 20;
   localparam int BOARD_COLS = 10;
   localparam int PIECE_DIM  = 4;

   // Lines cleared per lock never exceed the piece height.
   localparam logic [2:0] COUNT_MAX = 3'd4;

   // Element 0 is the top box row; bit PIECE_DIM-1 is the leftmost box column.
   typedef logic [PIECE_DIM-1:0]  piece_t [PIECE_DIM];

   // Element 0 is the top playfield row; bit BOARD_COLS-1 is column 0.
   typedef logic [BOARD_COLS-1:0] board_t [BOARD_ROWS];

   typedef enum logic [1:0] {
      IDLE,
      MERGE,
      SCAN,
      DONE
   } lock_state_t;

endpackage

// File: rtl/piece_stamp.sv
// Projects a 4x4 piece mask onto an empty playfield-sized mask at a signed
// position. Cells above the top edge raise above_top; cells off the sides
// or below the bottom are silently dropped.
module piece_stamp
   import tetris_pkg::*;
(
   input  piece_t            piece_rows,
   input  logic signed [4:0] piece_x,
   input  logic signed [5:0] piece_y,
   output board_t            mask,
   output logic              above_top
);

   logic signed [6:0] cell_row;
   logic signed [6:0] cell_col;

   // Walk every box cell and drop the set ones onto their playfield target.
   always_comb begin
      cell_row  = '0;
      cell_col  = '0;
      above_top = 1'b0;
      for (int i = 0; i < BOARD_ROWS; i++) begin
         mask[i] = '0;
      end
      for (int r = 0; r < PIECE_DIM; r++) begin
         for (int c = 0; c < PIECE_DIM; c++) begin
            // 7-bit signed sums cover -3..22 without wrap.
            cell_row = 7'(piece_y) + 7'(r);
            cell_col = 7'(piece_x) + 7'(c);
            if (piece_rows[r][PIECE_DIM-1-c]) begin
               if (cell_row < 0) begin
                  above_top = 1'b1;
               end else if ((cell_row < 7'(BOARD_ROWS)) && (cell_col >= 0) &&
                            (cell_col < 7'(BOARD_COLS))) begin
                  mask[cell_row[4:0]][4'(BOARD_COLS - 1 - int'(cell_col))] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/board_lock_clear.sv
// Owns the playfield. Locks a piece into it, then scans bottom-up for full
// rows, collapsing each one in place and counting them.
//
// Handshake: a request is taken on a rising edge where lock_valid and
// lock_ready are both high; the piece inputs are captured on that edge and
// are ignored at all other times. lock_ready stays low until the sequence
// ends, and done pulses for exactly one cycle with lines_cleared valid.
module board_lock_clear
   import tetris_pkg::*;
#(
   parameter int ROWS = BOARD_ROWS,
   parameter int COLS = BOARD_COLS
)
(
   input  logic              frame_clk,
   input  logic              Reset,
   input  logic              lock_valid,
   output logic              lock_ready,
   input  piece_t            piece_rows,
   input  logic signed [4:0] piece_x,
   input  logic signed [5:0] piece_y,
   output board_t            board,
   output logic [2:0]        lines_cleared,
   output logic              done,
   output logic              overflow,
   output lock_state_t       dbg_state
);

   lock_state_t       state_q;
   board_t            board_q;
   piece_t            piece_q;
   logic signed [4:0] px_q;
   logic signed [5:0] py_q;
   logic [4:0]        row_q;
   logic [2:0]        count_q;
   logic [2:0]        lines_q;
   logic              done_q;
   logic              over_q;
   logic              ready_q;

   board_t            stamp_mask;
   logic              stamp_above;
   logic              row_full;

   piece_stamp u_stamp (
      .piece_rows (piece_q),
      .piece_x    (px_q),
      .piece_y    (py_q),
      .mask       (stamp_mask),
      .above_top  (stamp_above)
   );

   assign row_full = (board_q[row_q] == {COLS{1'b1}});

   // Lock sequencer: capture, merge, scan/collapse, report.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q <= IDLE;
         for (int i = 0; i < ROWS; i++) begin
            board_q[i] <= '0;
         end
         for (int r = 0; r < PIECE_DIM; r++) begin
            piece_q[r] <= '0;
         end
         px_q    <= '0;
         py_q    <= '0;
         row_q   <= 5'(ROWS - 1);
         count_q <= '0;
         lines_q <= '0;
         done_q  <= 1'b0;
         over_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (lock_valid) begin
                  piece_q <= piece_rows;
                  px_q    <= piece_x;
                  py_q    <= piece_y;
                  ready_q <= 1'b0;
                  state_q <= MERGE;
               end
            end
            MERGE: begin
               // Overlap with existing blocks is a plain OR.
               for (int i = 0; i < ROWS; i++) begin
                  board_q[i] <= board_q[i] | stamp_mask[i];
               end
               over_q  <= over_q | stamp_above;
               row_q   <= 5'(ROWS - 1);
               count_q <= '0;
               state_q <= SCAN;
            end
            SCAN: begin
               if (row_full) begin
                  // Drop everything above the full row by one; retest this index.
                  for (int i = 1; i < ROWS; i++) begin
                     if (i <= int'(row_q)) begin
                        board_q[i] <= board_q[i-1];
                     end
                  end
                  board_q[0] <= '0;
                  if (count_q != COUNT_MAX) begin
                     count_q <= count_q + 3'd1;
                  end
               end else if (row_q == '0) begin
                  lines_q <= count_q;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  row_q <= row_q - 5'd1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign board         = board_q;
   assign lock_ready    = ready_q;
   assign lines_cleared = lines_q;
   assign done          = done_q;
   assign overflow      = over_q;
   assign dbg_state     = state_q;

endmodule
